bin2bcd_seq: RTL

Sequential binary-to-BCD converter that sits directly downstream of the combinational unsigned divider. It consumes the WIDTH-bit quotient and produces packed BCD digits for the display path. It uses the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock, with valid/ready handshakes on both sides.

---
 rtl/div_pkg.sv | 15 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 94 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and FSM encoding for the divider/BCD display path
package div_pkg;

    localparam int DIV_WIDTH   = 8;
    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } b2b_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj
    import div_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Inputs never exceed 9 in a legal accumulator, so the result fits in 4 bits (max 12).
    assign digit_o = (digit_i >= ADD3_THRESH) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter, one bit per clock
module bin2bcd_seq
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    b2b_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]  acc_q, acc_d;
    logic [BCD_W-1:0]  adj;
    logic              ovf_q, ovf_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // The bit leaving the top digit is a carry into 10^DIGITS; dropping it keeps the value modulo 10^DIGITS.
                {acc_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
                ovf_d            = ovf_q | adj[BCD_W-1];
                cnt_d            = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bcd      = acc_q;
    assign overflow = ovf_q;

endmodule
